// File: rtl/instr_queue_pkg.sv
// Constants and entry type shared between the instruction queue and decode
// (decode uses NOP_INSTR for bubble insertion).
package instr_queue_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int IQ_IW    = 32;
  localparam int IQ_PW    = 32;

  // addi x0, x0, 0
  localparam logic [IQ_IW-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [IQ_PW-1:0] pc;
    logic [IQ_IW-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// slave = the queue itself, master = the fetch/decode environment.
interface instr_queue_if #(
  parameter int DEPTH = instr_queue_pkg::IQ_DEPTH,
  parameter int IW    = instr_queue_pkg::IQ_IW,
  parameter int PW    = instr_queue_pkg::IQ_PW
);

  logic                       fe_valid;
  logic [IW-1:0]              fe_instr;
  logic [PW-1:0]              fe_pc;
  logic                       flush;
  logic                       fe_ready;
  logic                       dec_ready;
  logic                       dec_valid;
  logic [IW-1:0]              dec_instr;
  logic [PW-1:0]              dec_pc;
  logic [$clog2(DEPTH):0]     occupancy;

  modport master (
    output fe_valid, fe_instr, fe_pc, flush, dec_ready,
    input  fe_ready, dec_valid, dec_instr, dec_pc, occupancy
  );

  modport slave (
    input  fe_valid, fe_instr, fe_pc, flush, dec_ready,
    output fe_ready, dec_valid, dec_instr, dec_pc, occupancy
  );

endinterface

// File: rtl/instr_queue.sv
// First-word-fall-through instruction buffer between fetch and decode.
// Circular flop array with separate count; flush squashes everything in one cycle.
module instr_queue #(
  parameter int DEPTH = instr_queue_pkg::IQ_DEPTH,
  parameter int IW    = instr_queue_pkg::IQ_IW,
  parameter int PW    = instr_queue_pkg::IQ_PW
) (
  input  logic           clk,
  input  logic           rst,
  instr_queue_if.slave   bus
);

  import instr_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  iq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            fe_ready;
  logic            dec_valid;
  logic            push;
  logic            pop;
  logic [IW-1:0]   head_instr;
  logic [PW-1:0]   head_pc;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // A same-cycle pop frees the slot, so a full queue still accepts when decode drains.
  assign fe_ready  = ~full | bus.dec_ready;
  assign dec_valid = ~empty;

  assign push = bus.fe_valid & fe_ready  & ~bus.flush;
  assign pop  = dec_valid    & bus.dec_ready & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale slots are never visible because dec_valid gates the outputs.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= '{pc: bus.fe_pc, instr: bus.fe_instr};
    end
  end

  assign head_instr = mem[rd_ptr].instr;
  assign head_pc    = mem[rd_ptr].pc;

  assign bus.fe_ready  = fe_ready;
  assign bus.dec_valid = dec_valid;
  assign bus.dec_instr = dec_valid ? head_instr : NOP_INSTR;
  assign bus.dec_pc    = dec_valid ? head_pc    : '0;
  assign bus.occupancy = count;

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios plus a randomized run against a queue model.
module tb_instr_queue;

  import instr_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int PW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instr_queue_if #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) bus ();

  instr_queue #(.DEPTH(DEPTH), .IW(IW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.fe_valid  = 1'b0;
    bus.fe_instr  = '0;
    bus.fe_pc     = '0;
    bus.flush     = 1'b0;
    bus.dec_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.fe_valid = 1'b1;
    bus.fe_pc    = 32'h0000_0abc;
    bus.fe_instr = 32'hdead_beef;
    tick();
    tick();
    rst = 1'b0;
    bus.fe_valid = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.dec_instr !== 32'h13) begin n_err++; $display("FAIL reset_dec_instr: got %h want 00000013", bus.dec_instr); end
    n_cmp++; if (bus.dec_pc !== 32'h0) begin n_err++; $display("FAIL reset_dec_pc: got %h want 0", bus.dec_pc); end
    n_cmp++; if (bus.fe_ready !== 1'b1) begin n_err++; $display("FAIL reset_fe_ready: got %b want 1", bus.fe_ready); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] words [5];
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      words[i]      = $urandom;
      bus.fe_valid  = 1'b1;
      bus.fe_pc     = 32'(4 * i);
      bus.fe_instr  = words[i];
      #1;
      if (i == 4) begin
        n_cmp++; if (bus.occupancy !== 3'd4) begin n_err++; $display("FAIL fill_occ: got %0d want 4", bus.occupancy); end
        n_cmp++; if (bus.fe_ready !== 1'b0) begin n_err++; $display("FAIL fill_fe_ready: got %b want 0", bus.fe_ready); end
      end
      tick();
    end
    bus.fe_valid  = 1'b0;
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'(4 * i) || bus.dec_instr !== words[i])
        begin n_err++; $display("FAIL drain_%0d: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, bus.dec_valid, bus.dec_pc, bus.dec_instr, 32'(4 * i), words[i]); end
      tick();
    end
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.dec_instr !== NOP_INSTR)
      begin n_err++; $display("FAIL drain_empty: got v=%b occ=%0d ins=%h want v=0 occ=0 ins=%h", bus.dec_valid, bus.occupancy, bus.dec_instr, NOP_INSTR); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] pcs [5];
    logic [31:0] ins [5];
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      pcs[i] = 32'(4 * i);
      ins[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      bus.fe_valid = 1'b1;
      bus.fe_pc    = pcs[i];
      bus.fe_instr = ins[i];
      tick();
    end
    bus.fe_pc     = pcs[4];
    bus.fe_instr  = ins[4];
    bus.dec_ready = 1'b1;
    #1;
    n_cmp++; if (bus.fe_ready !== 1'b1) begin n_err++; $display("FAIL fullpp_fe_ready: got %b want 1", bus.fe_ready); end
    n_cmp++; if (bus.dec_pc !== pcs[0]) begin n_err++; $display("FAIL fullpp_head: got %h want %h", bus.dec_pc, pcs[0]); end
    tick();
    bus.fe_valid = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== 3'd4) begin n_err++; $display("FAIL fullpp_occ: got %0d want 4", bus.occupancy); end
    for (int i = 1; i < 5; i++) begin
      #1;
      n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== pcs[i] || bus.dec_instr !== ins[i])
        begin n_err++; $display("FAIL fullpp_out_%0d: got v=%b pc=%h ins=%h want pc=%h ins=%h", i, bus.dec_valid, bus.dec_pc, bus.dec_instr, pcs[i], ins[i]); end
      tick();
    end
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL fullpp_empty: got %b want 0", bus.dec_valid); end
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.fe_valid = 1'b1;
      bus.fe_pc    = 32'h100 + 32'(4 * i);
      bus.fe_instr = $urandom;
      tick();
    end
    #1;
    n_cmp++; if (bus.occupancy !== 3'd3) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 3", bus.occupancy); end
    bus.flush     = 1'b1;
    bus.fe_pc     = 32'h10c;
    bus.dec_ready = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.fe_valid = 1'b0;
    #1;
    n_cmp++; if (bus.occupancy !== 3'd0 || bus.dec_valid !== 1'b0 || bus.dec_instr !== NOP_INSTR)
      begin n_err++; $display("FAIL flush_empty: got occ=%0d v=%b ins=%h want occ=0 v=0 ins=%h", bus.occupancy, bus.dec_valid, bus.dec_instr, NOP_INSTR); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus.dec_valid !== 1'b0 || bus.dec_pc === 32'h10c)
        begin n_err++; $display("FAIL flush_ghost_%0d: got v=%b pc=%h want v=0", i, bus.dec_valid, bus.dec_pc); end
    end
    bus.fe_valid = 1'b1;
    bus.fe_pc    = 32'h200;
    bus.fe_instr = 32'h1234_5678;
    bus.dec_ready = 1'b0;
    tick();
    bus.fe_valid = 1'b0;
    #1;
    n_cmp++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h200 || bus.occupancy !== 3'd1)
      begin n_err++; $display("FAIL flush_refill: got v=%b pc=%h occ=%0d want v=1 pc=200 occ=1", bus.dec_valid, bus.dec_pc, bus.occupancy); end
    bus.dec_ready = 1'b1;
    tick();
  endtask

  task automatic test_miss_bubbles();
    logic        fv  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] fpc [5] = '{32'h20, 32'h0, 32'h0, 32'h24, 32'h0};
    logic        ev  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] epc [5] = '{32'h0, 32'h20, 32'h0, 32'h0, 32'h24};
    logic [31:0] ein [5];
    idle_inputs();
    bus.dec_ready = 1'b1;
    ein[0] = NOP_INSTR; ein[1] = 32'haaaa_0001; ein[2] = NOP_INSTR;
    ein[3] = NOP_INSTR; ein[4] = 32'haaaa_0002;
    for (int i = 0; i < 5; i++) begin
      bus.fe_valid = fv[i];
      bus.fe_pc    = fpc[i];
      bus.fe_instr = (i == 0) ? ein[1] : ein[4];
      #1;
      n_cmp++; if (bus.dec_valid !== ev[i] || bus.dec_pc !== epc[i] || bus.dec_instr !== ein[i])
        begin n_err++; $display("FAIL bubble_%0d: got v=%b pc=%h ins=%h want v=%b pc=%h ins=%h", i, bus.dec_valid, bus.dec_pc, bus.dec_instr, ev[i], epc[i], ein[i]); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [63:0] model [$];
    logic [31:0] pc_ctr = 32'h1000;
    logic        exp_ready, exp_valid, do_push, do_pop;
    logic [31:0] exp_pc, exp_ins;
    int          pv, pr;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      case ((cyc / 400) % 3)
        0:       begin pv = 85; pr = 30; end
        1:       begin pv = 30; pr = 85; end
        default: begin pv = 60; pr = 60; end
      endcase
      bus.fe_valid  = ($urandom_range(0, 99) < pv);
      bus.dec_ready = ($urandom_range(0, 99) < pr);
      bus.flush     = ($urandom_range(0, 99) == 0);
      bus.fe_pc     = pc_ctr;
      bus.fe_instr  = $urandom;
      #1;
      exp_ready = (model.size() < DEPTH) || bus.dec_ready;
      exp_valid = (model.size() > 0);
      exp_pc    = exp_valid ? model[0][63:32] : 32'h0;
      exp_ins   = exp_valid ? model[0][31:0]  : NOP_INSTR;
      n_cmp++; if (bus.fe_ready !== exp_ready || bus.dec_valid !== exp_valid || bus.occupancy !== 3'(model.size())
                   || bus.dec_pc !== exp_pc || bus.dec_instr !== exp_ins)
        begin n_err++; $display("FAIL random_c%0d: got rdy=%b v=%b occ=%0d pc=%h ins=%h want rdy=%b v=%b occ=%0d pc=%h ins=%h",
          cyc, bus.fe_ready, bus.dec_valid, bus.occupancy, bus.dec_pc, bus.dec_instr,
          exp_ready, exp_valid, model.size(), exp_pc, exp_ins); end
      do_push = bus.fe_valid && exp_ready;
      do_pop  = exp_valid && bus.dec_ready;
      if (bus.flush) begin
        model.delete();
      end else begin
        if (do_pop)  void'(model.pop_front());
        if (do_push) begin
          model.push_back({bus.fe_pc, bus.fe_instr});
          pc_ctr += 32'd4;
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_flush();
    test_miss_bubbles();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
